// File: rtl/sifive_scope_tlc_prot_capture.sv
// Debug-scope capture engine: snoops TileLink C-channel beats, filters on opcode/prot,
// and records timestamped entries into a circular trace buffer with pre/post-trigger capture.
module sifive_scope_tlc_prot_capture #(
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 16,
  parameter  int TS_W     = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int E_W      = TS_W + CH_W + 3 + 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   mon_valid,
  input  logic [CHANNELS-1:0]   mon_ready,
  input  logic [3*CHANNELS-1:0] mon_opcode,
  input  logic [7*CHANNELS-1:0] mon_prot,
  input  logic                  cfg_arm,
  input  logic                  cfg_stop,
  input  logic [6:0]            cfg_prot_mask,
  input  logic [6:0]            cfg_prot_match,
  input  logic                  cfg_trig_en,
  input  logic [2:0]            cfg_trig_opcode,
  input  logic [PTR_W-1:0]      cfg_post_count,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [E_W-1:0]        rd_data,
  output logic [1:0]            state,
  output logic [PTR_W:0]        level,
  output logic                  triggered,
  output logic [7:0]            drop_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [E_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] post_rem;
  logic [PTR_W-1:0] post_nxt;
  logic [TS_W-1:0]  ts;
  logic [3:0]       n_match;
  logic [CH_W-1:0]  win_ch;
  logic [2:0]       win_op;
  logic [6:0]       win_prot;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_nxt;
  logic             capturing;
  logic             arm_hit;
  logic             wr_en;
  logic             trig_hit;
  logic             pop;

  assign state = cur_state;

  // Scan high-to-low so the lowest-index matching channel is the one left as winner.
  always_comb begin
    n_match  = '0;
    win_ch   = '0;
    win_op   = '0;
    win_prot = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mon_valid[i] && mon_ready[i] &&
          ((mon_prot[7*i +: 7] & cfg_prot_mask) == (cfg_prot_match & cfg_prot_mask))) begin
        n_match  = n_match + 4'd1;
        win_ch   = CH_W'(i);
        win_op   = mon_opcode[3*i +: 3];
        win_prot = mon_prot[7*i +: 7];
      end
    end
  end

  assign capturing = (cur_state == S_ARMED) || (cur_state == S_POST);
  assign arm_hit   = cfg_arm && !cfg_stop && !capturing;
  assign wr_en     = capturing && !cfg_stop && (n_match != 4'd0);
  assign trig_hit  = wr_en && (cur_state == S_ARMED) && cfg_trig_en && (win_op == cfg_trig_opcode);
  assign pop       = (cur_state == S_DONE) && !arm_hit && rd_req && (level != '0);
  assign rd_ptr    = wr_ptr - level[PTR_W-1:0];

  always_comb begin
    drop_sum = '0;
    if (wr_en) begin
      drop_sum = {1'b0, drop_count} + {5'd0, n_match - 4'd1};
    end
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    nxt_state = cur_state;
    post_nxt  = post_rem;
    case (cur_state)
      S_IDLE: begin
        if (arm_hit) nxt_state = S_ARMED;
      end
      S_ARMED: begin
        if (cfg_stop) begin
          nxt_state = S_DONE;
        end else if (trig_hit) begin
          post_nxt  = cfg_post_count;
          nxt_state = (cfg_post_count == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (cfg_stop) begin
          nxt_state = S_DONE;
        end else if (wr_en) begin
          post_nxt = post_rem - PTR_W'(1);
          if (post_rem == PTR_W'(1)) nxt_state = S_DONE;
        end
      end
      S_DONE: begin
        if (arm_hit) nxt_state = S_ARMED;
      end
      default: nxt_state = S_IDLE;
    endcase
    if (arm_hit) post_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state  <= S_IDLE;
      post_rem   <= '0;
      ts         <= '0;
      level      <= '0;
      wr_ptr     <= '0;
      triggered  <= 1'b0;
      drop_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      cur_state <= nxt_state;
      post_rem  <= post_nxt;
      ts        <= arm_hit ? '0 : ts + TS_W'(1);
      rd_valid  <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (arm_hit) begin
        level      <= '0;
        wr_ptr     <= '0;
        triggered  <= 1'b0;
        drop_count <= '0;
      end else if (wr_en) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        drop_count <= drop_nxt;
        if (level != (PTR_W+1)'(DEPTH)) level <= level + (PTR_W+1)'(1);
        if (trig_hit) triggered <= 1'b1;
      end else if (pop) begin
        level <= level - (PTR_W+1)'(1);
      end
    end
  end

  // Trace storage is deliberately not reset; only the bookkeeping around it is.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_ptr] <= {ts, win_ch, win_op, win_prot};
  end

endmodule

// File: tb/tb_sifive_scope_tlc_prot_capture.sv
// Self-checking bench: directed scenarios plus random traffic compared against a
// queue-based behavioural model of the trace engine.
module tb_sifive_scope_tlc_prot_capture;

  localparam int CHANNELS = 4;
  localparam int DEPTH    = 16;
  localparam int TS_W     = 16;
  localparam int E_W      = TS_W + 2 + 3 + 7;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [CHANNELS-1:0]   mon_valid;
  logic [CHANNELS-1:0]   mon_ready;
  logic [3*CHANNELS-1:0] mon_opcode;
  logic [7*CHANNELS-1:0] mon_prot;
  logic                  cfg_arm;
  logic                  cfg_stop;
  logic [6:0]            cfg_prot_mask;
  logic [6:0]            cfg_prot_match;
  logic                  cfg_trig_en;
  logic [2:0]            cfg_trig_opcode;
  logic [3:0]            cfg_post_count;
  logic                  rd_req;
  logic                  rd_valid;
  logic [E_W-1:0]        rd_data;
  logic [1:0]            state;
  logic [4:0]            level;
  logic                  triggered;
  logic [7:0]            drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: trace buffer as a bounded queue, state as plain integers.
  logic [E_W-1:0] m_q[$];
  int             m_state;
  int             m_trig;
  int             m_drop;
  int             m_ts;
  int             m_post;
  int             m_rd_valid;
  logic [E_W-1:0] m_rd_data;

  sifive_scope_tlc_prot_capture #(
    .CHANNELS(CHANNELS),
    .DEPTH   (DEPTH),
    .TS_W    (TS_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mon_valid      (mon_valid),
    .mon_ready      (mon_ready),
    .mon_opcode     (mon_opcode),
    .mon_prot       (mon_prot),
    .cfg_arm        (cfg_arm),
    .cfg_stop       (cfg_stop),
    .cfg_prot_mask  (cfg_prot_mask),
    .cfg_prot_match (cfg_prot_match),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_trig_opcode(cfg_trig_opcode),
    .cfg_post_count (cfg_post_count),
    .rd_req         (rd_req),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .state          (state),
    .level          (level),
    .triggered      (triggered),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int             nm;
    int             win;
    logic [2:0]     op;
    logic [6:0]     pr;
    logic [15:0]    ts16;
    logic [1:0]     ch2;
    logic [E_W-1:0] entry;
    bit             capt;
    bit             arm_ok;
    nm  = 0;
    win = -1;
    op  = '0;
    pr  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mon_valid[i] && mon_ready[i] &&
          (((mon_prot[7*i +: 7] ^ cfg_prot_match) & cfg_prot_mask) == 7'd0)) begin
        nm++;
        if (win < 0) begin
          win = i;
          op  = mon_opcode[3*i +: 3];
          pr  = mon_prot[7*i +: 7];
        end
      end
    end
    if (reset) begin
      m_state = 0; m_q.delete(); m_trig = 0; m_drop = 0; m_ts = 0; m_post = 0;
      m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    ts16  = m_ts[15:0];
    ch2   = win[1:0];
    entry = {ts16, ch2, op, pr};
    m_rd_valid = 0;
    capt   = (m_state == 1) || (m_state == 2);
    arm_ok = cfg_arm && !cfg_stop && !capt;
    m_ts   = arm_ok ? 0 : (m_ts + 1) % 65536;
    if (!capt) begin
      if (arm_ok) begin
        m_q.delete(); m_trig = 0; m_drop = 0; m_post = 0; m_state = 1;
      end else if (m_state == 3 && rd_req && m_q.size() > 0) begin
        m_rd_data  = m_q.pop_front();
        m_rd_valid = 1;
      end
    end else if (cfg_stop) begin
      m_state = 3;
    end else if (nm > 0) begin
      m_q.push_back(entry);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_drop = (m_drop + nm - 1 > 255) ? 255 : m_drop + nm - 1;
      if (m_state == 1) begin
        if (cfg_trig_en && op == cfg_trig_opcode) begin
          m_trig = 1;
          m_post = cfg_post_count;
          m_state = (m_post == 0) ? 3 : 2;
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endtask

  // One clock: advance model, clock the DUT, compare, then drop single-cycle pulses.
  task automatic applyStimulus();
    modelStep();
    @(posedge clock);
    #1;
    checkOutput("state",      state,      m_state);
    checkOutput("level",      level,      m_q.size());
    checkOutput("triggered",  triggered,  m_trig);
    checkOutput("drop_count", drop_count, m_drop);
    checkOutput("rd_valid",   rd_valid,   m_rd_valid);
    checkOutput("rd_data",    rd_data,    m_rd_data);
    reset     = 1'b0;
    cfg_arm   = 1'b0;
    cfg_stop  = 1'b0;
    rd_req    = 1'b0;
    mon_valid = '0;
  endtask

  task automatic beat(input int ch, input logic [2:0] op, input logic [6:0] pr);
    mon_valid[ch]         = 1'b1;
    mon_ready[ch]         = 1'b1;
    mon_opcode[3*ch +: 3] = op;
    mon_prot[7*ch +: 7]   = pr;
  endtask

  task automatic setFilter(input logic [6:0] mask, input logic [6:0] mt, input logic ten,
                           input logic [2:0] top, input logic [3:0] post);
    cfg_prot_mask   = mask;
    cfg_prot_match  = mt;
    cfg_trig_en     = ten;
    cfg_trig_opcode = top;
    cfg_post_count  = post;
  endtask

  initial begin
    int popped_ops[$];
    reset = 1'b1; mon_valid = '0; mon_ready = '0; mon_opcode = '0; mon_prot = '0;
    cfg_arm = 1'b0; cfg_stop = 1'b0; rd_req = 1'b0;
    setFilter(7'h00, 7'h00, 1'b0, 3'd0, 4'd0);
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("reset_state", state, 0);
    checkOutput("reset_level", level, 0);

    // Basic capture of five beats then stop and drain.
    cfg_arm = 1'b1; applyStimulus();
    applyStimulus();
    for (int k = 0; k < 5; k++) begin beat(0, 3'($urandom_range(0, 7)), 7'h05); applyStimulus(); end
    cfg_stop = 1'b1; applyStimulus();
    checkOutput("t1_state", state, 3);
    checkOutput("t1_level", level, 5);
    for (int k = 0; k < 5; k++) begin
      rd_req = 1'b1; applyStimulus();
      checkOutput("t1_ts", rd_data[27:12], k + 1);
      checkOutput("t1_prot", rd_data[6:0], 7'h05);
    end
    rd_req = 1'b1; applyStimulus();
    checkOutput("t1_empty_pop", rd_valid, 0);

    // Wrap: twenty beats into a sixteen-deep buffer.
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 20; k++) begin beat(1, 3'($urandom_range(0, 7)), 7'($urandom)); applyStimulus(); end
    cfg_stop = 1'b1; applyStimulus();
    checkOutput("wrap_level", level, 16);
    rd_req = 1'b1; applyStimulus();
    checkOutput("wrap_first_ts", rd_data[27:12], 4);
    for (int k = 0; k < 16; k++) begin rd_req = 1'b1; applyStimulus(); end

    // Trigger with three post-trigger entries.
    setFilter(7'h00, 7'h00, 1'b1, 3'b110, 4'd3);
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 10; k++) begin beat(0, 3'($urandom_range(0, 5)), 7'($urandom)); applyStimulus(); end
    beat(0, 3'b110, 7'($urandom)); applyStimulus();
    for (int k = 0; k < 5; k++) begin
      beat(0, 3'($urandom_range(0, 5)), 7'($urandom)); applyStimulus();
      if (k == 2) checkOutput("trig_done", state, 3);
    end
    checkOutput("trig_sticky", triggered, 1);
    checkOutput("trig_level", level, 14);
    for (int k = 0; k < 14; k++) begin
      rd_req = 1'b1; applyStimulus();
      popped_ops.push_back(int'(rd_data[9:7]));
    end
    checkOutput("trig_entry_op", 64'(popped_ops[10]), 3'b110);

    // Contention across all four channels, then saturation.
    setFilter(7'h00, 7'h00, 1'b0, 3'd0, 4'd0);
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < CHANNELS; c++) beat(c, 3'(c), 7'($urandom));
      applyStimulus();
    end
    cfg_stop = 1'b1; applyStimulus();
    checkOutput("cont_level", level, 3);
    checkOutput("cont_drops", drop_count, 9);
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; applyStimulus();
      checkOutput("cont_chan", rd_data[11:10], 0);
    end
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < CHANNELS; c++) beat(c, 3'($urandom), 7'($urandom));
      applyStimulus();
    end
    checkOutput("cont_sat", drop_count, 255);
    cfg_stop = 1'b1; applyStimulus();

    // Prot filter: only secure beats are stored.
    setFilter(7'h10, 7'h10, 1'b0, 3'd0, 4'd0);
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 8; k++) begin beat(2, 3'd1, (k % 2 == 0) ? 7'h10 : 7'h00); applyStimulus(); end
    cfg_stop = 1'b1; applyStimulus();
    checkOutput("filt_level", level, 4);
    for (int k = 0; k < 4; k++) begin
      rd_req = 1'b1; applyStimulus();
      checkOutput("filt_prot", rd_data[6:0], 7'h10);
    end

    // Reset in the middle of POST, then re-arm from a cleared timestamp.
    setFilter(7'h00, 7'h00, 1'b1, 3'b110, 4'd10);
    cfg_arm = 1'b1; applyStimulus();
    for (int k = 0; k < 7; k++) begin beat(0, (k == 3) ? 3'b110 : 3'd0, 7'h01); applyStimulus(); end
    checkOutput("rst_pre_state", state, 2);
    checkOutput("rst_pre_level", level, 7);
    reset = 1'b1; applyStimulus();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_trig", triggered, 0);
    cfg_arm = 1'b1; applyStimulus();
    beat(0, 3'd1, 7'h02); applyStimulus();
    cfg_stop = 1'b1; applyStimulus();
    rd_req = 1'b1; applyStimulus();
    checkOutput("rearm_ts", rd_data[27:12], 0);

    // Random traffic and control against the model.
    for (int n = 0; n < 3000; n++) begin
      if (m_state == 0 || m_state == 3) begin
        if ($urandom_range(0, 15) == 0)
          setFilter(7'($urandom) & 7'h13, 7'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));
      end
      mon_valid  = CHANNELS'($urandom);
      mon_ready  = CHANNELS'($urandom);
      mon_opcode = 12'($urandom);
      mon_prot   = 28'($urandom) & 28'h4D3_34D3;
      cfg_arm    = ($urandom_range(0, 39) == 0);
      cfg_stop   = ($urandom_range(0, 59) == 0);
      rd_req     = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
